// File: rtl/freq_div_20bit.sv
// freq_div_20bit: free-running synchronous up-counter for power-of-two clock division.
// Exports the count, its MSB and a one-cycle wrap tick; `FREQ_DIV_TAP_EN adds a selectable bit tap.
module freq_div_20bit #(
    parameter int WIDTH = 20,
    parameter int TAP_W = 5
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
`ifdef FREQ_DIV_TAP_EN
    input  logic [TAP_W-1:0] TAP_SEL,
    output logic             TAP_OUT,
`endif
    output logic [WIDTH-1:0] COUNT,
    output logic             MSB,
    output logic             TICK
);

    if (WIDTH < 2 || WIDTH > 32 || (2 ** TAP_W) < WIDTH) begin : g_bad_param
        $error("freq_div_20bit: illegal WIDTH/TAP_W combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (EN) begin
            count_d = count_q + 1'b1;
            // Registered so the pulse lines up with the cycle where COUNT reads 0 after a wrap.
            tick_d  = (count_q == '1);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign COUNT = count_q;
    assign MSB   = count_q[WIDTH-1];
    assign TICK  = tick_q;

`ifdef FREQ_DIV_TAP_EN
    logic tap_q, tap_d;

    // Sampled from the next count so TAP_OUT tracks COUNT[TAP_SEL] in the same cycle.
    always_comb begin
        tap_d = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (TAP_SEL == TAP_W'(i)) tap_d = count_d[i];
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) tap_q <= 1'b0;
        else       tap_q <= tap_d;
    end

    assign TAP_OUT = tap_q;
`endif

endmodule

// File: tb/tb_freq_div_20bit.sv
// Directed bench for freq_div_20bit: vector table on a 4-bit instance, plus
// async-reset, free-run (10-bit scaled) and optional tap sequences.
module tb_freq_div_20bit;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] count4;
    logic       msb4, tick4;
    logic [9:0] count10;
    logic       msb10, tick10;
`ifdef FREQ_DIV_TAP_EN
    logic [2:0] tap_sel4;
    logic       tap_out4;
    logic [3:0] tap_sel10;
    logic       tap_out10;
`endif

    int checks = 0;
    int errors = 0;

    freq_div_20bit #(.WIDTH(4), .TAP_W(3)) u_dut4 (
        .CLOCK   (clk),
        .RESET   (rst),
        .EN      (en),
`ifdef FREQ_DIV_TAP_EN
        .TAP_SEL (tap_sel4),
        .TAP_OUT (tap_out4),
`endif
        .COUNT   (count4),
        .MSB     (msb4),
        .TICK    (tick4)
    );

    freq_div_20bit #(.WIDTH(10), .TAP_W(4)) u_dut10 (
        .CLOCK   (clk),
        .RESET   (rst),
        .EN      (en),
`ifdef FREQ_DIV_TAP_EN
        .TAP_SEL (tap_sel10),
        .TAP_OUT (tap_out10),
`endif
        .COUNT   (count10),
        .MSB     (msb10),
        .TICK    (tick10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] count;
        logic       msb;
        logic       tick;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic e, input logic [3:0] c, input logic t);
        vec_t v;
        v.rst   = r;
        v.en    = e;
        v.count = c;
        v.msb   = c[3];
        v.tick  = t;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int toggles[$];
    int tick_cnt;
    logic prev_msb;
    logic [3:0] m;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
`ifdef FREQ_DIV_TAP_EN
        tap_sel4  = 3'd0;
        tap_sel10 = 4'd0;
`endif

        // Reset with EN high, count through a wrap, pause, wrap again under EN gating.
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        for (int i = 1; i <= 15; i++) add(0, 1, 4'(i), 0);
        add(0, 1, 0, 1);
        for (int i = 1; i <= 5; i++) add(0, 1, 4'(i), 0);
        add(0, 0, 5, 0);
        add(0, 0, 5, 0);
        add(0, 0, 5, 0);
        for (int i = 6; i <= 15; i++) add(0, 1, 4'(i), 0);
        add(0, 0, 15, 0);
        add(0, 0, 15, 0);
        add(0, 1, 0, 1);
        add(0, 1, 1, 0);
        add(1, 1, 0, 0);
        add(1, 1, 0, 0);
        add(0, 1, 1, 0);

        #1;
        chk("reset_count_t0", 32'(count4), 0);
        chk("reset_tick_t0", 32'(tick4), 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            en  = vecs[i].en;
            step();
            chk($sformatf("vec%0d_count", i), 32'(count4), 32'(vecs[i].count));
            chk($sformatf("vec%0d_msb", i), 32'(msb4), 32'(vecs[i].msb));
            chk($sformatf("vec%0d_tick", i), 32'(tick4), 32'(vecs[i].tick));
        end

        // Async reset between edges at COUNT=11.
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 11; i++) step();
        chk("pre_async_count", 32'(count4), 11);
        chk("pre_async_msb", 32'(msb4), 1);
        #3 rst = 1'b1;
        #1;
        chk("async_count", 32'(count4), 0);
        chk("async_msb", 32'(msb4), 0);
        chk("async_tick", 32'(tick4), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_async_count", 32'(count4), 1);
        chk("post_async_tick", 32'(tick4), 0);

        // Async reset while the wrap tick is high.
        for (int i = 0; i < 14; i++) step();
        chk("pre_wrap_count", 32'(count4), 15);
        step();
        chk("wrap_count", 32'(count4), 0);
        chk("wrap_tick", 32'(tick4), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_tick_clear", 32'(tick4), 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("restart_count", 32'(count4), 1);
        chk("restart_tick", 32'(tick4), 0);

        // Scaled free-run on the 10-bit instance: two full periods of the MSB.
        rst = 1'b1;
        step();
        rst = 1'b0;
        en  = 1'b1;
        prev_msb = msb10;
        tick_cnt = 0;
        for (int n = 1; n <= 2048; n++) begin
            step();
            if (msb10 !== prev_msb) toggles.push_back(n);
            prev_msb = msb10;
            if (tick10 === 1'b1) tick_cnt++;
        end
        chk("free_toggle_count", 32'(toggles.size()), 4);
        for (int k = 0; k < toggles.size() && k < 4; k++)
            chk($sformatf("free_toggle%0d", k), 32'(toggles[k]), 32'(512 * (k + 1)));
        chk("free_tick_count", 32'(tick_cnt), 2);
        chk("free_end_count", 32'(count10), 0);

`ifdef FREQ_DIV_TAP_EN
        rst = 1'b1;
        tap_sel4 = 3'd1;
        step();
        chk("tap_reset", 32'(tap_out4), 0);
        rst = 1'b0;
        en  = 1'b1;
        m   = 4'd0;
        for (int i = 0; i < 12; i++) begin
            step();
            m = m + 4'd1;
            chk($sformatf("tap1_%0d", i), 32'(tap_out4), 32'(m[1]));
        end
        tap_sel4 = 3'd7;
        #1;
        chk("tap_sel_not_yet", 32'(tap_out4), 32'(m[1]));
        for (int i = 0; i < 16; i++) begin
            step();
            m = m + 4'd1;
            chk($sformatf("tap7_%0d", i), 32'(tap_out4), 0);
        end
        tap_sel4 = 3'd3;
        for (int i = 0; i < 16; i++) begin
            step();
            m = m + 4'd1;
            chk($sformatf("tap3_%0d", i), 32'(tap_out4), 32'(m[3]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
